// File: rtl/beacon_seq.sv
// Multi-channel LED pattern sequencer with a shared prescaled timebase and a
// double-buffered pattern register that is swapped in at start or loop wrap.
module beacon_seq #(
    parameter int unsigned TICK_DIV   = 400000,
    parameter int unsigned PAT_LEN    = 12,
    parameter int unsigned CHANNELS   = 1,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [CHANNELS*PAT_LEN-1:0]  load_pattern,
    input  logic                         mode,
    input  logic                         start,
    input  logic                         stop,
    output logic [CHANNELS-1:0]          out,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(PAT_LEN)-1:0]   step_idx
);

    localparam int unsigned PreW  = $clog2(TICK_DIV);
    localparam int unsigned StepW = $clog2(PAT_LEN);
    localparam int unsigned PatW  = CHANNELS * PAT_LEN;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [PreW-1:0]  PreLast  = PreW'(TICK_DIV - 1);
    localparam logic [StepW-1:0] StepLast = StepW'(PAT_LEN - 1);

    logic [0:0]       state_q, state_d;
    logic [PreW-1:0]  presc_q, presc_d;
    logic [StepW-1:0] step_q, step_d;
    logic [PatW-1:0]  active_q, active_d;
    logic [PatW-1:0]  shadow_q, shadow_d;
    logic             full_q, full_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;

    logic                               tick;
    logic [CHANNELS-1:0][PAT_LEN-1:0]   act_2d;
    logic [CHANNELS-1:0]                raw_out;

    assign tick = (presc_q == PreLast);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        step_d   = step_q;
        active_d = active_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        mode_d   = mode_q;
        done_d   = 1'b0;

        // A load can never coincide with a swap: both depend on full_q, with opposite sense.
        if (load_valid && !full_q) begin
            shadow_d = load_pattern;
            full_d   = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    presc_d = '0;
                    step_d  = '0;
                    mode_d  = mode;
                    if (full_q) begin
                        active_d = shadow_q;
                        full_d   = 1'b0;
                    end
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    presc_d = '0;
                    step_d  = '0;
                end else if (tick) begin
                    presc_d = '0;
                    if (step_q == StepLast) begin
                        step_d = '0;
                        if (mode_q) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else if (full_q) begin
                            active_d = shadow_q;
                            full_d   = 1'b0;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            step_q   <= '0;
            active_q <= '0;
            shadow_q <= '0;
            full_q   <= 1'b0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            step_q   <= step_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            full_q   <= full_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
        end
    end

    assign act_2d = active_q;

    always_comb begin
        raw_out = '0;
        if (state_q == StRun) begin
            for (int c = 0; c < CHANNELS; c++) begin
                raw_out[c] = act_2d[c][step_q];
            end
        end
    end

    assign out        = raw_out ^ {CHANNELS{ACTIVE_LOW != 0}};
    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign step_idx   = step_q;
    assign load_ready = !full_q;

endmodule

// File: tb/tb_beacon_seq.sv
// Scoreboard bench for beacon_seq: stimulus pushes the expected post-edge
// outputs, monitors pop and compare just after each rising edge.
module tb_beacon_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic       lv1, md1, st1, sp1;
    logic [7:0] pat1;
    logic       ready1, busy1, done1;
    logic [1:0] out1, idx1;
    logic       st2, md2;
    logic       ready2, busy2, done2;
    logic [1:0] out2, idx2;

    typedef struct packed {
        logic [1:0] o;
        logic       b;
        logic       d;
        logic [1:0] s;
        logic       r;
    } exp_t;

    exp_t  q1[$];
    exp_t  q2[$];
    int    compared = 0;
    int    mism     = 0;
    string phase    = "reset";

    always #5 CLK = ~CLK;

    beacon_seq #(.TICK_DIV(4), .PAT_LEN(4), .CHANNELS(2), .ACTIVE_LOW(0)) dut1 (
        .CLK(CLK), .RST(RST), .load_valid(lv1), .load_ready(ready1), .load_pattern(pat1),
        .mode(md1), .start(st1), .stop(sp1), .out(out1), .busy(busy1), .done(done1),
        .step_idx(idx1)
    );

    beacon_seq #(.TICK_DIV(4), .PAT_LEN(4), .CHANNELS(2), .ACTIVE_LOW(1)) dut2 (
        .CLK(CLK), .RST(RST), .load_valid(1'b0), .load_ready(ready2), .load_pattern(8'h00),
        .mode(md2), .start(st2), .stop(1'b0), .out(out2), .busy(busy2), .done(done2),
        .step_idx(idx2)
    );

    function automatic exp_t E(int o, int b, int d, int s, int r);
        return exp_t'({2'(o), 1'(b), 1'(d), 2'(s), 1'(r)});
    endfunction

    function automatic exp_t cur1();
        return exp_t'({out1, busy1, done1, idx1, ready1});
    endfunction

    function automatic exp_t cur2();
        return exp_t'({out2, busy2, done2, idx2, ready2});
    endfunction

    task automatic check(input string nm, input exp_t act, input exp_t ex);
        compared++;
        if (act !== ex) begin
            mism++;
            $display("FAIL %s/%s @%0t: got out=%b busy=%b done=%b step=%0d ready=%b; want out=%b busy=%b done=%b step=%0d ready=%b",
                     nm, phase, $time, act.o, act.b, act.d, act.s, act.r,
                     ex.o, ex.b, ex.d, ex.s, ex.r);
        end
    endtask

    // Monitors: compare one queued expectation per rising edge, if any was issued.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1", cur1(), e);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("dut2", cur2(), e);
            end
        end
    end

    task automatic cyc(input int lv, input int p, input int m, input int s, input int k,
                       input exp_t e);
        lv1  = 1'(lv);
        pat1 = 8'(p);
        md1  = 1'(m);
        st1  = 1'(s);
        sp1  = 1'(k);
        q1.push_back(e);
        @(negedge CLK);
    endtask

    task automatic idle(input exp_t e);
        cyc(0, 0, 0, 0, 0, e);
    endtask

    task automatic cyc2(input int s, input int m, input exp_t e);
        st2 = 1'(s);
        md2 = 1'(m);
        q2.push_back(e);
        @(negedge CLK);
    endtask

    int t1[4] = '{2, 1, 1, 2};

    initial begin
        RST = 1'b1;
        lv1 = 1'b0; pat1 = 8'h00; md1 = 1'b0; st1 = 1'b0; sp1 = 1'b0;
        st2 = 1'b0; md2 = 1'b0;
        @(negedge CLK);
        check("reset1", cur1(), E(0, 0, 0, 0, 1));
        check("reset2", cur2(), E(3, 0, 0, 0, 1));
        RST = 1'b0;
        @(negedge CLK);

        // One-shot with pattern 1001_0110.
        phase = "oneshot";
        cyc(1, 'b1001_0110, 0, 0, 0, E(0, 0, 0, 0, 0));
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (s == 0 && k == 0) cyc(0, 0, 1, 1, 0, E(t1[s], 1, 0, s, 1));
                else                  idle(E(t1[s], 1, 0, s, 1));
            end
        end
        idle(E(0, 0, 1, 0, 1));
        idle(E(0, 0, 0, 0, 1));

        // Loop with A=0x0F, B=0xF0 loaded during step 1, swapped at the wrap.
        phase = "loop";
        cyc(1, 'h0F, 0, 0, 0, E(0, 0, 0, 0, 0));
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                int r;
                r = (s == 0 || (s == 1 && k == 0)) ? 1 : 0;
                if (s == 0 && k == 0)      cyc(0, 0, 0, 1, 0, E(1, 1, 0, s, r));
                else if (s == 1 && k == 1) cyc(1, 'hF0, 0, 0, 0, E(1, 1, 0, s, r));
                else                       idle(E(1, 1, 0, s, r));
            end
        end
        for (int k = 0; k < 4; k++) idle(E(2, 1, 0, 0, 1));
        idle(E(2, 1, 0, 1, 1));
        cyc(0, 0, 0, 0, 1, E(0, 0, 0, 0, 1));

        // Start+stop in IDLE and in RUN; start ignored while running.
        phase = "stopstart";
        cyc(0, 0, 0, 1, 1, E(0, 0, 0, 0, 1));
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (s == 0 && k == 0)      cyc(0, 0, 0, 1, 0, E(2, 1, 0, s, 1));
                else if (s == 1 && k == 2) cyc(0, 0, 1, 1, 0, E(2, 1, 0, s, 1));
                else                       idle(E(2, 1, 0, s, 1));
            end
        end
        idle(E(2, 1, 0, 2, 1));
        cyc(0, 0, 0, 1, 1, E(0, 0, 0, 0, 1));
        idle(E(0, 0, 0, 0, 1));
        idle(E(0, 0, 0, 0, 1));

        // Asynchronous reset mid-step with a shadow pending.
        phase = "asyncrst";
        cyc(0, 0, 1, 1, 0, E(2, 1, 0, 0, 1));
        cyc(1, 'h3C, 0, 0, 0, E(2, 1, 0, 0, 0));
        idle(E(2, 1, 0, 0, 0));
        idle(E(2, 1, 0, 0, 0));
        idle(E(2, 1, 0, 1, 0));
        #2 RST = 1'b1;
        #1 check("async_rst1", cur1(), E(0, 0, 0, 0, 1));
        check("async_rst2", cur2(), E(3, 0, 0, 0, 1));
        @(negedge CLK);
        RST = 1'b0;
        idle(E(0, 0, 0, 0, 1));
        cyc(0, 0, 0, 1, 0, E(0, 1, 0, 0, 1));
        cyc(0, 0, 0, 0, 1, E(0, 0, 0, 0, 1));
        lv1 = 1'b0; st1 = 1'b0; sp1 = 1'b0; md1 = 1'b0;

        // Active-low instance, one-shot on the all-zero pattern.
        phase = "activelow";
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                if (s == 0 && k == 0) cyc2(1, 1, E(3, 1, 0, s, 1));
                else                  cyc2(0, 0, E(3, 1, 0, s, 1));
            end
        end
        cyc2(0, 0, E(3, 0, 1, 0, 1));
        cyc2(0, 0, E(3, 0, 0, 0, 1));

        repeat (2) @(negedge CLK);
        compared++;
        if (q1.size() != 0 || q2.size() != 0) begin
            mism++;
            $display("FAIL drain: got %0d/%0d expectations left; want 0/0", q1.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
